piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 120 ++++++++++++
 tb/tb_piso_serializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: accepts a word over valid/ready and
// shifts it out on q one bit per enabled clock, back-to-back with no idle bit.
module piso_serializer #(
   parameter int WIDTH      = 4,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             en,
   output logic             q,
   output logic             q_valid,
   output logic             q_last,
   output logic             busy
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [WIDTH-1:0] shreg, shreg_nx;
   logic             q_nx;
   logic             q_valid_nx;
   logic             at_last;
   logic             accept;

   // Bit that goes on the line next, taken from the end selected by MSB_FIRST.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   // Remaining bits after the head bit has been moved onto q.
   function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? (w << 1) : (w >> 1);
   endfunction

   assign at_last   = (state == SHIFT) && (cnt == CNT_LAST);
   assign din_ready = rst_n && ((state == IDLE) || (at_last && en));
   assign accept    = din_valid && din_ready;
   assign q_last    = at_last;
   assign busy      = (state == SHIFT);

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      shreg_nx   = shreg;
      q_nx       = q;
      q_valid_nx = q_valid;

      case (state)
         IDLE: begin
            q_nx       = IDLE_LEVEL;
            q_valid_nx = 1'b0;
            if (accept) begin
               state_nx   = SHIFT;
               cnt_nx     = '0;
               q_nx       = head_bit(din);
               shreg_nx   = drop_head(din);
               q_valid_nx = 1'b1;
            end
         end

         SHIFT: begin
            if (en) begin
               if (!at_last) begin
                  cnt_nx   = cnt + 1'b1;
                  q_nx     = head_bit(shreg);
                  shreg_nx = drop_head(shreg);
               end else if (accept) begin
                  // Reload on the last bit so the next word follows without a gap.
                  cnt_nx     = '0;
                  q_nx       = head_bit(din);
                  shreg_nx   = drop_head(din);
                  q_valid_nx = 1'b1;
               end else begin
                  state_nx   = IDLE;
                  cnt_nx     = '0;
                  shreg_nx   = '0;
                  q_nx       = IDLE_LEVEL;
                  q_valid_nx = 1'b0;
               end
            end
         end

         default: begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            shreg_nx   = '0;
            q_nx       = IDLE_LEVEL;
            q_valid_nx = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         shreg   <= '0;
         q       <= IDLE_LEVEL;
         q_valid <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         shreg   <= shreg_nx;
         q       <= q_nx;
         q_valid <= q_valid_nx;
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first/idle-0 and an LSB-first/idle-1 instance
// share one stimulus stream and are checked against a word/position model.
module tb_piso_serializer;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] din;
   logic         din_valid;
   logic         en;

   logic din_ready_m, q_m, q_valid_m, q_last_m, busy_m;
   logic din_ready_l, q_l, q_valid_l, q_last_l, busy_l;

   int checks   = 0;
   int failures = 0;

   // Reference model: the word in flight and which bit position is on the line.
   bit           m_act;
   logic [W-1:0] m_word;
   int           m_pos;

   int          span;
   logic [15:0] cap_m;
   logic [15:0] cap_l;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready_m),
      .en        (en),
      .q         (q_m),
      .q_valid   (q_valid_m),
      .q_last    (q_last_m),
      .busy      (busy_m)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready_l),
      .en        (en),
      .q         (q_l),
      .q_valid   (q_valid_l),
      .q_last    (q_last_l),
      .busy      (busy_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_q(input bit msb, input bit idle);
      if (!m_act) return idle;
      return msb ? m_word[W-1-m_pos] : m_word[m_pos];
   endfunction

   // One clock: apply inputs, check ready before the edge, advance model, check outputs after.
   task automatic cyc(input logic r, input logic e, input logic v, input logic [W-1:0] d);
      logic exp_ready;
      logic acc;
      rst_n     = r;
      en        = e;
      din_valid = v;
      din       = d;
      #1;
      exp_ready = r && (!m_act || ((m_pos == W-1) && e));
      chk1("din_ready_msb", din_ready_m, exp_ready);
      chk1("din_ready_lsb", din_ready_l, exp_ready);
      acc = v && exp_ready;
      @(posedge clk);
      if (!r) begin
         m_act = 1'b0;
         m_pos = 0;
      end else if (!m_act) begin
         if (acc) begin
            m_act  = 1'b1;
            m_word = d;
            m_pos  = 0;
         end
      end else if (e) begin
         if (m_pos < W-1) begin
            m_pos++;
         end else if (acc) begin
            m_word = d;
            m_pos  = 0;
         end else begin
            m_act = 1'b0;
            m_pos = 0;
         end
      end
      #1;
      chk1("q_msb",       q_m,       exp_q(1'b1, 1'b0));
      chk1("q_lsb",       q_l,       exp_q(1'b0, 1'b1));
      chk1("q_valid_msb", q_valid_m, m_act);
      chk1("q_valid_lsb", q_valid_l, m_act);
      chk1("q_last_msb",  q_last_m,  m_act && (m_pos == W-1));
      chk1("q_last_lsb",  q_last_l,  m_act && (m_pos == W-1));
      chk1("busy_msb",    busy_m,    m_act);
      chk1("busy_lsb",    busy_l,    m_act);
      if (q_valid_m) begin
         span++;
         cap_m = {cap_m[14:0], q_m};
         cap_l = {cap_l[14:0], q_l};
      end
   endtask

   task automatic clear_cap();
      span  = 0;
      cap_m = '0;
      cap_l = '0;
   endtask

   initial begin
      rst_n     = 1'b0;
      en        = 1'b1;
      din_valid = 1'b0;
      din       = '0;
      m_act     = 1'b0;
      m_word    = '0;
      m_pos     = 0;
      clear_cap();

      // Reset state, with a valid word offered that must not be taken.
      cyc(1'b0, 1'b1, 1'b1, 4'b1010);
      cyc(1'b0, 1'b1, 1'b0, 4'b0000);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000);

      // Single word, then idle.
      clear_cap();
      cyc(1'b1, 1'b1, 1'b1, 4'b1011);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      chkn("single_bits_msb", 32'(cap_m[3:0]), 32'(4'b1011));
      chkn("single_bits_lsb", 32'(cap_l[3:0]), 32'(4'b1101));
      chkn("single_span", span, 4);

      // Back-to-back words with the second held valid.
      clear_cap();
      cyc(1'b1, 1'b1, 1'b1, 4'b1011);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 4'b0110);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      chkn("b2b_bits_msb", 32'(cap_m[7:0]), 32'(8'b10110110));
      chkn("b2b_bits_lsb", 32'(cap_l[7:0]), 32'(8'b11010110));
      chkn("b2b_span", span, 8);

      // Stall on bit 2 for three cycles.
      clear_cap();
      cyc(1'b1, 1'b1, 1'b1, 4'b1001);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 4'b0000);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      chkn("stall_span", span, 7);

      // Stall on the last bit with a word waiting: ready must stay low until en returns.
      cyc(1'b1, 1'b1, 1'b1, 4'b1001);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 4'b0111);
      cyc(1'b1, 1'b1, 1'b1, 4'b0111);
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 4'b0000);

      // Reset mid-word, then a clean word afterwards.
      cyc(1'b1, 1'b1, 1'b1, 4'b1111);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      cyc(1'b0, 1'b1, 1'b1, 4'b0101);
      cyc(1'b0, 1'b1, 1'b1, 4'b0101);
      clear_cap();
      cyc(1'b1, 1'b1, 1'b1, 4'b0101);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      chkn("post_reset_msb", 32'(cap_m[3:0]), 32'(4'b0101));
      chkn("post_reset_lsb", 32'(cap_l[3:0]), 32'(4'b1010));
      chkn("post_reset_span", span, 4);

      // A word offered mid-transfer must be ignored.
      clear_cap();
      cyc(1'b1, 1'b1, 1'b1, 4'b1100);
      cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      cyc(1'b1, 1'b1, 1'b1, 4'b0001);
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 4'b0000);
      chkn("reject_bits_msb", 32'(cap_m[3:0]), 32'(4'b1100));
      chkn("reject_bits_lsb", 32'(cap_l[3:0]), 32'(4'b0011));
      chkn("reject_span", span, 4);

      // Randomized traffic with stalls and occasional resets.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 63) != 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 1) != 0) ? 1'b1 : 1'b0,
             4'($urandom));
      end
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
